as_sc_hs_prbs7_checker: RTL

//  Serial PRBS-7 (x^7+x^6+1) checker for silicon characterisation of the hs cell library.

---
 rtl/as_sc_hs_test_pkg.sv | 26 ++
 rtl/as_sc_hs_sat_cnt.sv | 38 +++
 rtl/as_sc_hs_prbs7_checker.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/as_sc_hs_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : as_sc_hs_test_pkg
//  Purpose  : Shared definitions for the hs-cell characterisation test loop:
//             checker state encoding, PRBS-7 (x^7+x^6+1) taps and the
//             one-step PRBS-7 shift function used by checker and generator.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package as_sc_hs_test_pkg;

    typedef enum logic [0:0] {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // Taps for x^7 and x^6: feedback bit is sr[6] ^ sr[5].
    localparam logic [6:0] c_PRBS7_TAPS = 7'b110_0000;

    // Advance the PRBS-7 register by one bit, new bit enters at the LSB.
    function automatic logic [6:0] prbs7_next(input logic [6:0] sr);
        return {sr[5:0], ^(sr & c_PRBS7_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/as_sc_hs_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : as_sc_hs_sat_cnt
//  Purpose  : W-bit up-counter that sticks at all-ones instead of wrapping.
//             Clear has priority over increment.
//  Ports    : clk  - clock
//             rst  - synchronous active-high reset
//             clr  - synchronous clear to zero
//             inc  - increment request
//             cnt  - current count
//  Revision : 1.0 - initial release
// ============================================================================
module as_sc_hs_sat_cnt
    import as_sc_hs_test_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/as_sc_hs_prbs7_checker.sv
`default_nettype none
// ============================================================================
//  Module   : as_sc_hs_prbs7_checker
//  Purpose  : Self-synchronising serial PRBS-7 checker. In SEEK the received
//             bits are loaded into the shift register until LOCK_CNT
//             consecutive bits agree with the prediction; in LOCKED the
//             register free-runs and each received bit is compared against it.
//             Too many errors inside one evaluation window drops lock.
//  Ports    : clk      - clock
//             rst      - synchronous active-high reset
//             en       - din valid this cycle (all state holds when low)
//             din      - received serial bit
//             clr_cnt  - synchronous clear of err_cnt / bit_cnt
//             locked   - high while in LOCKED
//             err      - registered one-cycle pulse for a mismatched bit
//             err_cnt  - saturating mismatch count while LOCKED
//             bit_cnt  - saturating compared-bit count while LOCKED
//  Revision : 1.0 - initial release
// ============================================================================
module as_sc_hs_prbs7_checker
    import as_sc_hs_test_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int WIN      = 128,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int c_MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int c_WIN_W   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int c_LOSS_W  = $clog2(LOSS_THR + 1);

    chk_state_t           r_state, w_state_nxt;
    logic [6:0]           r_sr, w_sr_nxt;
    logic [c_MATCH_W-1:0] r_match, w_match_nxt;
    logic [c_WIN_W-1:0]   r_win, w_win_nxt;
    logic [c_LOSS_W-1:0]  r_loss, w_loss_nxt;
    logic                 r_err, w_err_nxt;
    logic                 w_pred, w_mis;
    logic [c_LOSS_W-1:0]  w_loss_sum;
    logic                 w_bit_inc, w_err_inc;

    assign w_pred     = ^(r_sr & c_PRBS7_TAPS);
    assign w_mis      = (din != w_pred);
    // Stored loss never exceeds LOSS_THR-1, so the sum always fits.
    assign w_loss_sum = r_loss + c_LOSS_W'(w_mis);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEEK;
            r_sr    <= 7'h00;
            r_match <= '0;
            r_win   <= '0;
            r_loss  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_match <= w_match_nxt;
            r_win   <= w_win_nxt;
            r_loss  <= w_loss_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_match_nxt = r_match;
        w_win_nxt   = r_win;
        w_loss_nxt  = r_loss;
        w_err_nxt   = 1'b0;
        w_bit_inc   = 1'b0;
        w_err_inc   = 1'b0;
        if (en) begin
            case (r_state)
                SEEK: begin
                    w_sr_nxt = {r_sr[5:0], din};
                    // An all-zero register predicts zeros forever; a dead
                    // link must never be mistaken for lock.
                    if ((r_sr != 7'h00) && !w_mis) begin
                        if (r_match == c_MATCH_W'(LOCK_CNT - 1)) begin
                            w_state_nxt = LOCKED;
                            w_match_nxt = '0;
                            w_win_nxt   = '0;
                            w_loss_nxt  = '0;
                        end else begin
                            w_match_nxt = r_match + c_MATCH_W'(1);
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                LOCKED: begin
                    w_sr_nxt  = prbs7_next(r_sr);
                    w_err_nxt = w_mis;
                    w_bit_inc = 1'b1;
                    w_err_inc = w_mis;
                    // Loss check first so a threshold hit on the window's
                    // last bit still drops lock.
                    if (w_loss_sum == c_LOSS_W'(LOSS_THR)) begin
                        w_state_nxt = SEEK;
                        w_match_nxt = '0;
                        w_sr_nxt    = 7'h00;
                        w_win_nxt   = '0;
                        w_loss_nxt  = '0;
                    end else if (r_win == c_WIN_W'(WIN - 1)) begin
                        w_win_nxt  = '0;
                        w_loss_nxt = '0;
                    end else begin
                        w_win_nxt  = r_win + c_WIN_W'(1);
                        w_loss_nxt = w_loss_sum;
                    end
                end
                default: begin
                    w_state_nxt = SEEK;
                end
            endcase
        end
    end

    as_sc_hs_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_err_inc),
        .cnt (err_cnt)
    );

    as_sc_hs_sat_cnt #(.W(CNT_W)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_bit_inc),
        .cnt (bit_cnt)
    );

    assign locked = (r_state == LOCKED);
    assign err    = r_err;

endmodule
`default_nettype wire
